// File: rtl/rom_access_ctrl.sv
// -----------------------------------------------------------------------------
// rom_access_ctrl
//
// Sequences and arbitrates access to the single-port ROM block. Port A
// (instruction fetch, read only) and port B (loader, read/write) share the ROM
// port under round-robin arbitration. The controller also drives the ROM
// initialize sequence after reset and whenever init_req is raised in IDLE.
// Each access takes three cycles: grant (ISSUE), ROM latency (WAIT), and
// completion (back in IDLE).
//
// Ports
//   clk            system clock, rising edge
//   clear          asynchronous active-high reset
//   init_req       level request to rerun ROM initialize (sampled in IDLE)
//   a_req/a_addr   port A read request and address (held until a_gnt)
//   a_gnt          one-cycle pulse: port A request accepted
//   a_rvalid       one-cycle pulse: a_rdata updated
//   a_rdata        port A read data, held until the next A completion
//   b_req/b_we     port B request and write enable (held until b_gnt)
//   b_addr/b_wdata port B address and write data
//   b_gnt          one-cycle pulse: port B request accepted
//   b_rvalid       one-cycle pulse: port B access complete (read or write)
//   b_rdata        port B read data, unchanged on write completion
//   rom_WE, rom_Address, rom_initialize, rom_D   registered ROM controls
//   rom_Q          ROM read data, valid the cycle after the address edge
//   busy           high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module rom_access_ctrl #(
    parameter int n  = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          init_req,

    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [n-1:0]  a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [n-1:0]  b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [n-1:0]  b_rdata,

    output logic          rom_WE,
    output logic [AW-1:0] rom_Address,
    output logic          rom_initialize,
    output logic [n-1:0]  rom_D,
    input  logic [n-1:0]  rom_Q,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t         state_q;
    logic           init_pend_q;  // initialize still owed (set by reset)
    logic           last_b_q;     // 1: port B was granted most recently
    logic           owner_b_q;    // owner of the access in flight
    logic           owner_rd_q;   // access in flight is a read
    logic           a_gnt_q, b_gnt_q, a_rvalid_q, b_rvalid_q;
    logic [n-1:0]   a_rdata_q, b_rdata_q;
    logic           rom_we_q, rom_init_q;
    logic [AW-1:0]  rom_addr_q;
    logic [n-1:0]   rom_d_q;

    // A wins when it is the sole requester, or on a tie when B went last.
    logic pick_a;
    assign pick_a = a_req && (!b_req || last_b_q);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            init_pend_q <= 1'b1;
            last_b_q    <= 1'b1;
            owner_b_q   <= 1'b0;
            owner_rd_q  <= 1'b0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            rom_we_q    <= 1'b0;
            rom_init_q  <= 1'b0;
            rom_addr_q  <= '0;
            rom_d_q     <= '0;
        end else begin
            // Handshake outputs are single-cycle pulses.
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (init_pend_q || init_req) begin
                        rom_init_q  <= 1'b1;
                        init_pend_q <= 1'b0;
                        state_q     <= INIT;
                    end else if (a_req || b_req) begin
                        if (pick_a) begin
                            rom_addr_q <= a_addr;
                            rom_we_q   <= 1'b0;
                            rom_d_q    <= '0;
                            a_gnt_q    <= 1'b1;
                            owner_b_q  <= 1'b0;
                            owner_rd_q <= 1'b1;
                            last_b_q   <= 1'b0;
                        end else begin
                            rom_addr_q <= b_addr;
                            rom_we_q   <= b_we;
                            rom_d_q    <= b_we ? b_wdata : '0;
                            b_gnt_q    <= 1'b1;
                            owner_b_q  <= 1'b1;
                            owner_rd_q <= !b_we;
                            last_b_q   <= 1'b1;
                        end
                        state_q <= ISSUE;
                    end
                end
                INIT: begin
                    rom_init_q <= 1'b0;
                    state_q    <= IDLE;
                end
                ISSUE: begin
                    // ROM samples address/WE/D at this edge.
                    rom_we_q <= 1'b0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (owner_b_q) begin
                        b_rvalid_q <= 1'b1;
                        if (owner_rd_q) b_rdata_q <= rom_Q;
                    end else begin
                        a_rvalid_q <= 1'b1;
                        if (owner_rd_q) a_rdata_q <= rom_Q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_gnt          = a_gnt_q;
    assign b_gnt          = b_gnt_q;
    assign a_rvalid       = a_rvalid_q;
    assign b_rvalid       = b_rvalid_q;
    assign a_rdata        = a_rdata_q;
    assign b_rdata        = b_rdata_q;
    assign rom_WE         = rom_we_q;
    assign rom_Address    = rom_addr_q;
    assign rom_initialize = rom_init_q;
    assign rom_D          = rom_d_q;
    assign busy           = (state_q != IDLE);

endmodule
